// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the sisc core.
// Takes a byte stream (16-bit big-endian word count, 4*N payload bytes,
// one XOR checksum byte) and writes big-endian 32-bit words into
// instruction memory at consecutive addresses. It holds the core in reset
// until the checksum has been verified.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        im_we,
   output logic [15:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_rst_f,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] index_q, index_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] asm_q, asm_d;       // first three bytes of the word being built
   logic [7:0]  csum_q, csum_d;
   logic        byte_ready_q, byte_ready_d;
   logic        im_we_q, im_we_d;
   logic [15:0] im_addr_q, im_addr_d;
   logic [31:0] im_wdata_q, im_wdata_d;
   logic        cpu_rst_f_q, cpu_rst_f_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        xfer;
   logic [15:0] hdr_count;

   // A byte moves only when the registered ready is high.
   assign xfer      = byte_valid && byte_ready_q;
   assign hdr_count = {count_q[15:8], byte_data};

   // Next-state logic; every output register is derived from the next state
   // so that outputs are valid in the same cycle the state is entered.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      index_d    = index_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      csum_d     = csum_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d    = S_HDR_HI;
               count_d    = 16'd0;
               index_d    = 16'd0;
               byte_cnt_d = 2'd0;
               csum_d     = 8'd0;
            end
         end
         S_HDR_HI: begin
            if (xfer) begin
               count_d[15:8] = byte_data;
               csum_d        = csum_q ^ byte_data;
               state_d       = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (xfer) begin
               count_d = hdr_count;
               csum_d  = csum_q ^ byte_data;
               if ({16'd0, hdr_count} > MAX_W) begin
                  state_d = S_ERROR;
               end else if (hdr_count == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               csum_d     = csum_q ^ byte_data;
               asm_d      = {asm_q[15:0], byte_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d    = S_WRITE;
                  im_wdata_d = {asm_q, byte_data};
                  im_addr_d  = BASE_ADDR + index_q;   // wraps modulo 2^16
               end
            end
         end
         S_WRITE: begin
            index_d = index_q + 16'd1;
            if (index_q + 16'd1 == count_q) begin
               state_d = S_CSUM;
            end else begin
               state_d = S_DATA;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               if (byte_data == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      byte_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
      im_we_d      = (state_d == S_WRITE);
      done_d       = (state_d == S_DONE);
      cpu_rst_f_d  = (state_d == S_DONE);
      err_d        = (state_d == S_ERROR);
   end

   // State and output registers, cleared asynchronously by RST.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_IDLE;
         count_q      <= 16'd0;
         index_q      <= 16'd0;
         byte_cnt_q   <= 2'd0;
         asm_q        <= 24'd0;
         csum_q       <= 8'd0;
         byte_ready_q <= 1'b0;
         im_we_q      <= 1'b0;
         im_addr_q    <= 16'd0;
         im_wdata_q   <= 32'd0;
         cpu_rst_f_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         index_q      <= index_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         csum_q       <= csum_d;
         byte_ready_q <= byte_ready_d;
         im_we_q      <= im_we_d;
         im_addr_q    <= im_addr_d;
         im_wdata_q   <= im_wdata_d;
         cpu_rst_f_q  <= cpu_rst_f_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign im_we      = im_we_q;
   assign im_addr    = im_addr_q;
   assign im_wdata   = im_wdata_q;
   assign cpu_rst_f  = cpu_rst_f_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (default parameters, and
// BASE_ADDR=FFFF / MAX_WORDS=4) share the byte bus; only the started one
// is ready. A stream-level model predicts writes, write timing and outcome.
module tb_imem_loader;

   localparam int          MAXW0 = 1024;
   localparam int          MAXW1 = 4;
   localparam logic [15:0] BASE0 = 16'h0000;
   localparam logic [15:0] BASE1 = 16'hFFFF;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start [2];
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready [2];
   logic        im_we [2];
   logic [15:0] im_addr [2];
   logic [31:0] im_wdata [2];
   logic        cpu_rst_f [2];
   logic        done [2];
   logic        err [2];

   imem_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAXW0)) u0 (
      .CLK(CLK), .RST(RST), .start(start[0]), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready[0]), .im_we(im_we[0]),
      .im_addr(im_addr[0]), .im_wdata(im_wdata[0]), .cpu_rst_f(cpu_rst_f[0]),
      .done(done[0]), .err(err[0]));

   imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAXW1)) u1 (
      .CLK(CLK), .RST(RST), .start(start[1]), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready[1]), .im_we(im_we[1]),
      .im_addr(im_addr[1]), .im_wdata(im_wdata[1]), .cpu_rst_f(cpu_rst_f[1]),
      .done(done[1]), .err(err[1]));

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [47:0] exp0 [$];     // expected {addr, data} writes, instance 0
   logic [47:0] exp1 [$];     // expected {addr, data} writes, instance 1
   logic [7:0]  stream_q [$];

   // stream-level tracking used by the per-cycle compare process
   int          cnt [2];
   logic [7:0]  hi_b [2];
   logic [15:0] nw [2];
   bit          busy [2];
   bit          pend [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int maxw(input int k);
      return (k == 1) ? MAXW1 : MAXW0;
   endfunction

   function automatic logic [15:0] basea(input int k);
      return (k == 1) ? BASE1 : BASE0;
   endfunction

   task automatic push_exp(input int k, input logic [47:0] v);
      if (k == 0) exp0.push_back(v);
      else exp1.push_back(v);
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_ready"}, 64'(byte_ready[k]), 64'd0);
         chk({tag, "_we"},    64'(im_we[k]),      64'd0);
         chk({tag, "_addr"},  64'(im_addr[k]),    64'd0);
         chk({tag, "_wdata"}, 64'(im_wdata[k]),   64'd0);
         chk({tag, "_rstf"},  64'(cpu_rst_f[k]),  64'd0);
         chk({tag, "_done"},  64'(done[k]),       64'd0);
         chk({tag, "_err"},   64'(err[k]),        64'd0);
      end
   endtask

   // Per-cycle compare: write timing, write contents, output invariants.
   initial begin
      logic [47:0] e;
      forever begin
         @(negedge CLK);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (RST) begin
               busy[k] = 1'b0;
               cnt[k]  = 0;
               pend[k] = 1'b0;
            end else begin
               chk("we_timing", 64'(im_we[k]), 64'(pend[k]));
               if (im_we[k]) begin
                  chk("ready_in_write", 64'(byte_ready[k]), 64'd0);
                  if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
                     chk("unexpected_write", 64'(im_addr[k]), 64'hDEAD_0000_0000);
                  end else begin
                     e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                     chk("write_addr", 64'(im_addr[k]),  64'(e[47:32]));
                     chk("write_data", 64'(im_wdata[k]), 64'(e[31:0]));
                  end
               end
               chk("rstf_eq_done", 64'(cpu_rst_f[k]), 64'(done[k]));
               chk("done_err_excl", 64'(done[k] & err[k]), 64'd0);
               pend[k] = 1'b0;
               if (done[k] || err[k]) busy[k] = 1'b0;
               if (start[k] && !busy[k]) begin
                  busy[k] = 1'b1;
                  cnt[k]  = 0;
               end else if (busy[k] && byte_valid && byte_ready[k]) begin
                  cnt[k]++;
                  if (cnt[k] == 1) begin
                     hi_b[k] = byte_data;
                  end else if (cnt[k] == 2) begin
                     nw[k] = {hi_b[k], byte_data};
                  end else if (int'(nw[k]) <= maxw(k) && cnt[k] <= 2 + 4 * int'(nw[k]) &&
                               ((cnt[k] - 2) % 4) == 0) begin
                     pend[k] = 1'b1;   // 4th byte of a word: write pulse next cycle
                  end
               end
            end
         end
      end
   end

   // Random stream of n words; returns expected outcome and byte count.
   task automatic build(input int k, input int n, input bit bad,
                        output bit exp_done, output int nbytes);
      logic [7:0]  cs;
      logic [31:0] w;
      logic [15:0] n16;
      n16 = 16'(n);
      stream_q.delete();
      stream_q.push_back(n16[15:8]);
      stream_q.push_back(n16[7:0]);
      cs = n16[15:8] ^ n16[7:0];
      if (n > maxw(k)) begin
         exp_done = 1'b0;
         nbytes   = 2;
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int b = 3; b >= 0; b--) begin
            stream_q.push_back(w[b*8 +: 8]);
            cs = cs ^ w[b*8 +: 8];
         end
         push_exp(k, {basea(k) + 16'(i), w});
      end
      if (bad) cs = cs ^ (8'h01 << ($urandom % 8));
      stream_q.push_back(cs);
      exp_done = !bad;
      nbytes   = stream_q.size();
   endtask

   // Present stream bytes until `limit` have transferred.
   // mode 0: valid always, 1: toggling, 2: random.
   task automatic feed(input int k, input int limit, input int mode, input bit mid_start);
      int idx = 0;
      int guard = 0;
      bit did = 1'b0;
      bit v;
      while (idx < limit) begin
         @(negedge CLK);
         start[k] = 1'b0;
         guard++;
         if (guard > 2000) begin
            chk("feed_timeout", 64'(idx), 64'(limit));
            break;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2) == 1;
            default: v = ($urandom % 2) == 1;
         endcase
         byte_valid = v;
         byte_data  = stream_q[idx];
         if (mid_start && idx == 4 && !did) begin
            start[k] = 1'b1;   // must be ignored while loading
            did      = 1'b1;
         end
         if (v && byte_ready[k]) idx++;
      end
      @(negedge CLK);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start[k]   = 1'b0;
   endtask

   task automatic do_load(input int k, input int mode, input bit mid_start,
                          input bit exp_done, input int nbytes, input bit oversize);
      int g = 0;
      @(negedge CLK);
      start[k] = 1'b1;
      @(negedge CLK);
      start[k] = 1'b0;
      chk("start_ready",    64'(byte_ready[k]), 64'd1);
      chk("start_done_low", 64'(done[k]),       64'd0);
      chk("start_rstf_low", 64'(cpu_rst_f[k]),  64'd0);
      chk("start_err_low",  64'(err[k]),        64'd0);
      feed(k, nbytes, mode, mid_start);
      if (oversize) begin
         chk("oversize_err_now",   64'(err[k]),        64'd1);
         chk("oversize_ready_low", 64'(byte_ready[k]), 64'd0);
      end
      while (!(done[k] || err[k]) && g < 100) begin
         @(negedge CLK);
         g++;
      end
      chk("final_done", 64'(done[k]),      64'(exp_done));
      chk("final_err",  64'(err[k]),       64'(!exp_done));
      chk("final_rstf", 64'(cpu_rst_f[k]), 64'(exp_done));
      chk("all_writes_seen", 64'((k == 0) ? exp0.size() : exp1.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ed;
      int nb;
      int k;
      int n;
      RST        = 1'b1;
      start[0]   = 1'b0;
      start[1]   = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge CLK);
      chk_reset_vals("reset");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // Nominal: header/payload XOR = 00^02 ^ 00 = 02.
      stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
      exp0.push_back({16'h0000, 32'h1234_5678});
      exp0.push_back({16'h0001, 32'h9ABC_DEF0});
      do_load(0, 0, 1'b0, 1'b1, 11, 1'b0);

      // Bad checksum: words still written, then error (restart from DONE).
      stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hFF};
      exp0.push_back({16'h0000, 32'h1234_5678});
      exp0.push_back({16'h0001, 32'h9ABC_DEF0});
      do_load(0, 0, 1'b0, 1'b0, 11, 1'b0);

      // Zero count: done, no writes (restart from ERROR).
      stream_q = '{8'h00, 8'h00, 8'h00};
      do_load(0, 0, 1'b0, 1'b1, 3, 1'b0);

      // Oversize count on the MAX_WORDS=4 instance.
      stream_q = '{8'h00, 8'h05};
      do_load(1, 0, 1'b0, 1'b0, 2, 1'b1);

      // Address wrap with throttled source: checksum 02^44^CC = 8A.
      stream_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
      exp1.push_back({16'hFFFF, 32'h1122_3344});
      exp1.push_back({16'h0000, 32'h5566_7788});
      do_load(1, 1, 1'b0, 1'b1, 11, 1'b0);

      // Reset during the 3rd payload byte of word 1.
      build(0, 2, 1'b0, ed, nb);
      @(negedge CLK);
      start[0] = 1'b1;
      @(negedge CLK);
      start[0] = 1'b0;
      feed(0, 4, 0, 1'b0);
      @(negedge CLK);
      byte_valid = 1'b1;
      byte_data  = stream_q[4];
      #3;
      RST = 1'b1;
      #1;
      chk_reset_vals("midload_reset");
      exp0.delete();
      byte_valid = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("post_reset_idle_ready", 64'(byte_ready[0]), 64'd0);
      build(0, 3, 1'b0, ed, nb);
      do_load(0, 2, 1'b0, ed, nb, 1'b0);

      // Start during DATA must be ignored.
      build(0, 3, 1'b0, ed, nb);
      do_load(0, 0, 1'b1, ed, nb, 1'b0);

      // Randomized loads on both instances.
      for (int t = 0; t < 30; t++) begin
         bit bad;
         bit mid;
         int mode;
         k    = int'($urandom % 2);
         n    = (k == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 8));
         bad  = ($urandom % 4) == 0;
         mode = int'($urandom % 3);
         mid  = (n > 0) && (n <= maxw(k)) && (($urandom % 3) == 0);
         build(k, n, bad, ed, nb);
         do_load(k, mode, mid, ed, nb, n > maxw(k));
      end

      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
